// File: rtl/id_ex_pipeline_reg_if.sv
// Decoded-instruction bundle passed between the ID and EX stages.
// The pipeline register consumes one instance through the slave modport and drives another through the master modport.
interface id_ex_pipeline_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              regdst;
    logic              memread;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regwrite;
    logic              branch;
    logic              jump;
    logic              jump_r;
    logic              jal;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;

    modport master (
        output regdst, memread, memtoreg, memwrite, alusrc, regwrite,
               branch, jump, jump_r, jal, aluop,
               pc4, rd1, rd2, imm, rs, rt, rd, shamt, funct
    );

    modport slave (
        input  regdst, memread, memtoreg, memwrite, alusrc, regwrite,
               branch, jump, jump_r, jal, aluop,
               pc4, rd1, rd2, imm, rs, rt, rd, shamt, funct
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream hold and a saturating load-use bubble counter.
module id_ex_pipeline_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_ex_pipeline_reg_if.slave  id,
    id_ex_pipeline_reg_if.master ex,
    input  logic                 id_flush,
    input  logic                 hold,
    output logic                 ex_valid,
    output logic                 hazard_stall,
    output logic [CNT_W-1:0]     bubble_count
);

    // Control word layout: ten single-bit flags followed by the 2-bit ALU op.
    localparam int CTRL_W = 12;

    logic [CTRL_W-1:0] id_ctrl;
    logic [CTRL_W-1:0] ctrl_reg,   ctrl_next;
    logic [DATA_W-1:0] pc4_reg,    pc4_next;
    logic [DATA_W-1:0] rd1_reg,    rd1_next;
    logic [DATA_W-1:0] rd2_reg,    rd2_next;
    logic [DATA_W-1:0] imm_reg,    imm_next;
    logic [REG_AW-1:0] rs_reg,     rs_next;
    logic [REG_AW-1:0] rt_reg,     rt_next;
    logic [REG_AW-1:0] rd_reg,     rd_next;
    logic [4:0]        shamt_reg,  shamt_next;
    logic [5:0]        funct_reg,  funct_next;
    logic              valid_reg,  valid_next;
    logic [CNT_W-1:0]  count_reg,  count_next;

    logic uses_rt;
    logic load_use;

    assign id_ctrl = {id.regdst, id.memread, id.memtoreg, id.memwrite,
                      id.alusrc, id.regwrite, id.branch, id.jump,
                      id.jump_r, id.jal, id.aluop};

    // Only R-type, stores and branches actually read rt as a source operand.
    assign uses_rt  = id.regdst | id.memwrite | id.branch;

    // ex_valid gating guarantees a bubble can never itself trigger a stall.
    assign load_use = ex.memread & valid_reg & (rt_reg != '0) &
                      ((rt_reg == id.rs) | ((rt_reg == id.rt) & uses_rt));

    assign hazard_stall = load_use & ~id_flush;

    always_comb begin
        ctrl_next  = ctrl_reg;
        pc4_next   = pc4_reg;
        rd1_next   = rd1_reg;
        rd2_next   = rd2_reg;
        imm_next   = imm_reg;
        rs_next    = rs_reg;
        rt_next    = rt_reg;
        rd_next    = rd_reg;
        shamt_next = shamt_reg;
        funct_next = funct_reg;
        valid_next = valid_reg;
        count_next = count_reg;

        if (!hold) begin
            // Data fields follow ID even into a bubble; only control is squashed.
            pc4_next   = id.pc4;
            rd1_next   = id.rd1;
            rd2_next   = id.rd2;
            imm_next   = id.imm;
            rs_next    = id.rs;
            rt_next    = id.rt;
            rd_next    = id.rd;
            shamt_next = id.shamt;
            funct_next = id.funct;

            if (id_flush) begin
                ctrl_next  = '0;
                valid_next = 1'b0;
            end else if (load_use) begin
                ctrl_next  = '0;
                valid_next = 1'b0;
                if (count_reg != {CNT_W{1'b1}})
                    count_next = count_reg + 1'b1;
            end else begin
                ctrl_next  = id_ctrl;
                valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg  <= '0;
            pc4_reg   <= '0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
            shamt_reg <= '0;
            funct_reg <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            ctrl_reg  <= ctrl_next;
            pc4_reg   <= pc4_next;
            rd1_reg   <= rd1_next;
            rd2_reg   <= rd2_next;
            imm_reg   <= imm_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            rd_reg    <= rd_next;
            shamt_reg <= shamt_next;
            funct_reg <= funct_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    assign {ex.regdst, ex.memread, ex.memtoreg, ex.memwrite,
            ex.alusrc, ex.regwrite, ex.branch, ex.jump,
            ex.jump_r, ex.jal, ex.aluop} = ctrl_reg;

    assign ex.pc4   = pc4_reg;
    assign ex.rd1   = rd1_reg;
    assign ex.rd2   = rd2_reg;
    assign ex.imm   = imm_reg;
    assign ex.rs    = rs_reg;
    assign ex.rt    = rt_reg;
    assign ex.rd    = rd_reg;
    assign ex.shamt = shamt_reg;
    assign ex.funct = funct_reg;

    assign ex_valid     = valid_reg;
    assign bubble_count = count_reg;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: reset, capture, load-use bubbles,
// false-hazard filtering, flush/hold priority, counter saturation, reset mid-stall.
module tb_id_ex_pipeline_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_flush;
    logic             hold;
    logic             ex_valid;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_count;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    id_ex_pipeline_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) id_bus ();
    id_ex_pipeline_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) ex_bus ();

    id_ex_pipeline_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id           (id_bus.slave),
        .ex           (ex_bus.master),
        .id_flush     (id_flush),
        .hold         (hold),
        .ex_valid     (ex_valid),
        .hazard_stall (hazard_stall),
        .bubble_count (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            $display("[TB] %s obs=%0h exp=%0h ok", tag, obs, exp);
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_bus.regdst = 0; id_bus.memread = 0; id_bus.memtoreg = 0;
        id_bus.memwrite = 0; id_bus.alusrc = 0; id_bus.regwrite = 0;
        id_bus.branch = 0; id_bus.jump = 0; id_bus.jump_r = 0; id_bus.jal = 0;
        id_bus.aluop = 2'b00;
        id_bus.pc4 = 32'h0000_0104; id_bus.rd1 = 32'h1111_0001;
        id_bus.rd2 = 32'h2222_0002; id_bus.imm = 32'h0;
        id_bus.rs = 0; id_bus.rt = 0; id_bus.rd = 0;
        id_bus.shamt = 0; id_bus.funct = 0;
    endtask

    task automatic set_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        clr();
        id_bus.regdst = 1; id_bus.regwrite = 1; id_bus.aluop = 2'b10;
        id_bus.rs = rs; id_bus.rt = rt; id_bus.rd = rd; id_bus.funct = 6'h20;
    endtask

    task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs);
        clr();
        id_bus.memread = 1; id_bus.memtoreg = 1; id_bus.alusrc = 1; id_bus.regwrite = 1;
        id_bus.rs = rs; id_bus.rt = rt;
    endtask

    task automatic set_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] imm);
        clr();
        id_bus.alusrc = 1; id_bus.regwrite = 1;
        id_bus.rs = rs; id_bus.rt = rt; id_bus.imm = imm;
    endtask

    task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt);
        clr();
        id_bus.branch = 1; id_bus.aluop = 2'b01;
        id_bus.rs = rs; id_bus.rt = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_flush = 1'b0; hold = 1'b0;
        set_lw(5'd5, 5'd1);
        id_bus.rd = 5'd9; id_bus.pc4 = 32'hDEAD_BEEF;
        #2;
        chk("rst_async_valid", {31'b0, ex_valid}, 32'd0);
        step(); step();
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_count", {30'b0, bubble_count}, 32'd0);
        chk("rst_memread", {31'b0, ex_bus.memread}, 32'd0);
        chk("rst_regwrite", {31'b0, ex_bus.regwrite}, 32'd0);
        chk("rst_rd", {27'b0, ex_bus.rd}, 32'd0);
        chk("rst_pc4", ex_bus.pc4, 32'd0);
        chk("rst_stall", {31'b0, hazard_stall}, 32'd0);

        // Release reset and capture add $3,$1,$2
        rst_n = 1'b1;
        set_add(5'd3, 5'd1, 5'd2);
        step();
        chk("add_regwrite", {31'b0, ex_bus.regwrite}, 32'd1);
        chk("add_rd", {27'b0, ex_bus.rd}, 32'd3);
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_aluop", {30'b0, ex_bus.aluop}, 32'd2);
        chk("add_rd1", ex_bus.rd1, 32'h1111_0001);

        // Load-use: lw $5,0($1) then add $6,$5,$2
        set_lw(5'd5, 5'd1);
        #1 chk("lw_no_stall", {31'b0, hazard_stall}, 32'd0);
        step();
        set_add(5'd6, 5'd5, 5'd2);
        #1 chk("lu_stall", {31'b0, hazard_stall}, 32'd1);
        step();
        exp_cnt = 1;
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_memread", {31'b0, ex_bus.memread}, 32'd0);
        chk("lu_bubble_regwrite", {31'b0, ex_bus.regwrite}, 32'd0);
        chk("lu_bubble_regdst", {31'b0, ex_bus.regdst}, 32'd0);
        chk("lu_bubble_aluop", {30'b0, ex_bus.aluop}, 32'd0);
        chk("lu_bubble_rs_data", {27'b0, ex_bus.rs}, 32'd5);
        chk("lu_count", {30'b0, bubble_count}, exp_cnt);
        chk("lu_stall_drops", {31'b0, hazard_stall}, 32'd0);
        step();
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, ex_bus.rd}, 32'd6);
        chk("lu_add_regwrite", {31'b0, ex_bus.regwrite}, 32'd1);
        chk("lu_count_hold", {30'b0, bubble_count}, exp_cnt);

        // $0 never hazards
        set_lw(5'd0, 5'd1);
        step();
        set_add(5'd6, 5'd0, 5'd2);
        #1 chk("zero_no_stall", {31'b0, hazard_stall}, 32'd0);
        step();

        // rs match with uses_rt=0, then rt match alone with uses_rt=0
        set_lw(5'd5, 5'd1);
        step();
        set_addi(5'd7, 5'd5, 32'd4);
        #1 chk("addi_rs_stall", {31'b0, hazard_stall}, 32'd1);
        set_addi(5'd5, 5'd1, 32'd4);
        #1 chk("addi_rt_no_stall", {31'b0, hazard_stall}, 32'd0);
        step();
        chk("addi_captured", {31'b0, ex_valid}, 32'd1);
        chk("addi_imm", ex_bus.imm, 32'd4);
        chk("addi_count", {30'b0, bubble_count}, exp_cnt);

        // Flush beats load-use
        set_lw(5'd5, 5'd1);
        step();
        set_beq(5'd5, 5'd6);
        id_flush = 1'b1;
        #1 chk("flush_stall", {31'b0, hazard_stall}, 32'd0);
        step();
        id_flush = 1'b0;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_branch", {31'b0, ex_bus.branch}, 32'd0);
        chk("flush_count", {30'b0, bubble_count}, exp_cnt);

        // Hold with load-use pending for 3 cycles
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stall", {31'b0, hazard_stall}, 32'd1);
            chk("hold_memread", {31'b0, ex_bus.memread}, 32'd1);
            chk("hold_rt", {27'b0, ex_bus.rt}, 32'd5);
            chk("hold_count", {30'b0, bubble_count}, exp_cnt);
        end
        hold = 1'b0;
        step();
        exp_cnt = 2;
        chk("hold_rel_valid", {31'b0, ex_valid}, 32'd0);
        chk("hold_rel_count", {30'b0, bubble_count}, exp_cnt);
        step();
        chk("hold_rel_add", {27'b0, ex_bus.rd}, 32'd6);

        // Three more load-use events: counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            set_lw(5'd5, 5'd1);
            step();
            set_add(5'd6, 5'd2, 5'd5);
            step();
            if (exp_cnt < 3) exp_cnt++;
            chk("sat_count", {30'b0, bubble_count}, exp_cnt);
            step();
            chk("sat_add_valid", {31'b0, ex_valid}, 32'd1);
        end

        // Reset in the middle of a stall
        set_lw(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd2);
        #1 chk("mid_stall_pre", {31'b0, hazard_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, hazard_stall}, 32'd0);
        chk("mid_rst_count", {30'b0, bubble_count}, 32'd0);
        chk("mid_rst_memread", {31'b0, ex_bus.memread}, 32'd0);
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        step();
        chk("post_rst_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("post_rst_add_rd", {27'b0, ex_bus.rd}, 32'd6);
        chk("post_rst_count", {30'b0, bubble_count}, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
